// File: rtl/md_pkg.sv
// Shared constants and state type for the multiply/divide stall sequencer.
package md_pkg;

  localparam logic [4:0] OP_ALU     = 5'b00000;
  localparam logic [4:0] ALUOP_MUL  = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;
  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE
  } md_state_e;

endpackage

// File: rtl/md_decode.sv
// Combinational mul/div recogniser for the fetched instruction word.
module md_decode
  import md_pkg::*;
(
  input  logic [31:0] q_imem,
  input  logic        instr_valid,
  output logic        is_mul,
  output logic        is_div,
  output logic [4:0]  rd
);

  logic alu_op;
  logic unused_bits;

  assign alu_op = instr_valid && (q_imem[31:27] == OP_ALU);
  assign is_mul = alu_op && (q_imem[6:2] == ALUOP_MUL);
  assign is_div = alu_op && (q_imem[6:2] == ALUOP_DIV);
  assign rd     = q_imem[26:22];

  assign unused_bits = ^{q_imem[21:7], q_imem[1:0]};

endmodule

// File: rtl/md_stall_sequencer.sv
// Freezes fetch while the iterative mul/div unit runs, then issues
// exactly one regfile writeback (result to rd, or exception code to r30).
module md_stall_sequencer
  import md_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned CNT_W        = 7,
  parameter int unsigned MUL_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] q_imem,
  input  logic        instr_valid,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  input  logic [31:0] data_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        busy,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  md_state_e        state_q;
  logic             mul_q;
  logic [4:0]       rd_q;
  logic [31:0]      res_q;
  logic             exc_q;
  logic [CNT_W-1:0] cnt_q;

  logic       is_mul;
  logic       is_div;
  logic [4:0] dec_rd;
  logic       md;

  md_decode u_decode (
    .q_imem      (q_imem),
    .instr_valid (instr_valid),
    .is_mul      (is_mul),
    .is_div      (is_div),
    .rd          (dec_rd)
  );

  // Gated by reset so every output is low while reset is held.
  assign md = (is_mul || is_div) && reset_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mul_q   <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (md) begin
            mul_q   <= is_mul;
            rd_q    <= dec_rd;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          exc_q   <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (data_resultRDY) begin
            res_q   <= data_result;
            exc_q   <= data_exception;
            state_q <= WRITE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            exc_q   <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall   = 1'b0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    unique case (state_q)
      IDLE:  stall = md;
      ISSUE: stall = 1'b1;
      WAIT:  stall = 1'b1;
      WRITE: begin
        if (exc_q) begin
          wb_en   = 1'b1;
          wb_addr = REG_STATUS;
          wb_data = mul_q ? 32'(MUL_EXC_CODE)
                          : 32'(DIV_EXC_CODE);
        end else if (rd_q != 5'd0) begin
          wb_en   = 1'b1;
          wb_addr = rd_q;
          wb_data = res_q;
        end
      end
      default: stall = 1'b0;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign ctrl_MULT = (state_q == ISSUE) && mul_q;
  assign ctrl_DIV  = (state_q == ISSUE) && !mul_q;

endmodule

// File: tb/tb_md_stall_sequencer.sv
// Randomised bench for md_stall_sequencer against a cycle-timeline model.
module tb_md_stall_sequencer;

  localparam int TMO = 64;

  logic        clock;
  logic        reset_n;
  logic [31:0] q_imem;
  logic        instr_valid;
  logic        data_resultRDY;
  logic        data_exception;
  logic [31:0] data_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        busy;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  md_stall_sequencer #(
    .TIMEOUT      (TMO),
    .CNT_W        (7),
    .MUL_EXC_CODE (4),
    .DIV_EXC_CODE (5)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .q_imem         (q_imem),
    .instr_valid    (instr_valid),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .data_result    (data_result),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .stall          (stall),
    .busy           (busy),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [41:0] outs();
    return {stall, busy, ctrl_MULT, ctrl_DIV,
            wb_en, wb_addr, wb_data};
  endfunction

  // Whole-op model: RDY d cycles after the start pulse (d<=0: never).
  // Derives the cycle of the writeback and every output per cycle.
  task automatic run_op(input logic [31:0] instr, input int d,
                        input logic exc, input logic [31:0] res);
    logic       mul;
    logic [4:0] rd;
    logic       tmo;
    logic       xe;
    int         k;
    int         w;
    logic [41:0] e;
    logic [41:0] g;
    logic        en;
    mul = (instr[6:2] == 5'b00110);
    rd  = instr[26:22];
    k   = 1 + d;
    tmo = (d <= 0) || (k > TMO + 1);
    w   = tmo ? TMO + 2 : k + 1;
    xe  = tmo ? 1'b1 : exc;
    for (int t = 0; t <= w; t++) begin
      if (t == 0) begin
        q_imem      = instr;
        instr_valid = 1'b1;
      end else begin
        q_imem      = $urandom;
        instr_valid = 1'($urandom);
      end
      data_resultRDY = !tmo && (t == k);
      data_exception = data_resultRDY ? exc : 1'($urandom);
      data_result    = data_resultRDY ? res : $urandom;
      @(negedge clock);
      en = (t == w) && (xe || rd != 5'd0);
      e  = {t < w, t >= 1, t == 1 && mul, t == 1 && !mul, en,
            en ? (xe ? 5'd30 : rd) : 5'd0,
            en ? (xe ? (mul ? 32'd4 : 32'd5) : res) : 32'd0};
      g  = outs();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL op instr=%h d=%0d t=%0d got=%h exp=%h",
                 instr, d, t, g, e);
      end
      @(posedge clock);
      #1;
    end
    instr_valid    = 1'b0;
    data_resultRDY = 1'b0;
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      total++;
      if (outs() !== 42'd0) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h exp=0", name, i, outs());
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    q_imem         = 32'h00C22018;
    instr_valid    = 1'b1;
    data_resultRDY = 1'b1;
    data_exception = 1'b0;
    data_result    = 32'hFFFF_FFFF;
    #2;
    total++;
    if (outs() !== 42'd0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", outs());
    end
    @(negedge clock);
    instr_valid    = 1'b0;
    data_resultRDY = 1'b0;
    reset_n        = 1'b1;
    @(posedge clock);
    #1;
    idle_check("after_reset", 2);
  endtask

  task automatic test_directed();
    run_op(32'h00C22018, 3, 1'b0, 32'h0000_002A);
    run_op(32'h010A601C, 2, 1'b1, 32'h1234_5678);
    run_op(32'h00022018, 1, 1'b0, 32'h0000_0007);
  endtask

  task automatic test_timeout();
    run_op(32'h00C22018, 0, 1'b0, 32'h0);
    run_op(32'h010A601C, 0, 1'b0, 32'h0);
    run_op(32'h00C22018, 64, 1'b0, 32'hCAFE_0001);
    run_op(32'h010A601C, 63, 1'b0, 32'hCAFE_0002);
  endtask

  task automatic test_reset_mid();
    q_imem      = 32'h00C22018;
    instr_valid = 1'b1;
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (outs() !== 42'd0) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=0", outs());
    end
    @(negedge clock);
    instr_valid = 1'b0;
    reset_n     = 1'b1;
    @(posedge clock);
    #1;
    data_resultRDY = 1'b1;
    data_exception = 1'b0;
    data_result    = 32'h0000_0099;
    @(negedge clock);
    total++;
    if (outs() !== 42'd0) begin
      bad++;
      $display("FAIL late_rdy got=%h exp=0", outs());
    end
    @(posedge clock);
    #1;
    data_resultRDY = 1'b0;
    idle_check("post_late_rdy", 2);
  endtask

  task automatic test_non_md();
    logic [31:0] w [4];
    logic        v [4];
    w[0] = 32'h00C22000; v[0] = 1'b1;
    w[1] = 32'h00C22018; v[1] = 1'b0;
    w[2] = 32'h08C22018; v[2] = 1'b1;
    w[3] = 32'h00C22014; v[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_imem         = w[i];
      instr_valid    = v[i];
      data_resultRDY = 1'($urandom);
      data_result    = $urandom;
      idle_check("non_md", 2);
    end
    data_resultRDY = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_op(32'h00C22018, 1, 1'b0, 32'h1111_1111);
    run_op(32'h010A601C, 1, 1'b0, 32'h2222_2222);
    run_op(32'h00022018, 2, 1'b1, 32'h3333_3333);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [4:0]  rd;
    int          d;
    for (int i = 0; i < 30; i++) begin
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      ins = {5'b0, rd, 15'($urandom),
             ($urandom_range(0, 1) == 1) ? 5'b00110 : 5'b00111,
             2'($urandom)};
      d   = $urandom_range(1, 10);
      run_op(ins, d, $urandom_range(0, 3) == 0, $urandom);
      if ($urandom_range(0, 2) == 0) idle_check("rand_gap", 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_non_md();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_stall_sequencer.md
Name: md_stall_sequencer

Overview:
- Multi-cycle sequencer for the iterative multiply/divide unit in the single-cycle processor.
- Decodes mul/div from the fetched instruction, freezes PC/fetch, pulses the unit's start line, and waits for ready or timeout.
- Produces one register-file writeback: the result to rd, or an exception code to the status register r30.
- Sits between instruction decode and the regfile writeback mux.

Parameters:
- TIMEOUT, 64, WAIT-state cycles before the op is abandoned as an exception.
- CNT_W, 7, wait-counter width; must satisfy 2^CNT_W > TIMEOUT.
- MUL_EXC_CODE, 4, value written to r30 on mul exception/timeout.
- DIV_EXC_CODE, 5, value written to r30 on div exception/timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- q_imem  in  32  current instruction.
- instr_valid  in  1  q_imem holds a valid instruction this cycle.
- data_resultRDY  in  1  unit result valid (single-cycle pulse).
- data_exception  in  1  unit overflow/div-by-zero, sampled with data_resultRDY.
- data_result  in  32  unit result.
- ctrl_MULT  out  1  one-cycle start pulse, multiply.
- ctrl_DIV  out  1  one-cycle start pulse, divide.
- stall  out  1  hold PC and fetch.
- busy  out  1  sequencer not in IDLE.
- wb_en  out  1  regfile write enable from this block.
- wb_addr  out  5  write register.
- wb_data  out  32  write data.

Behaviour:
- Decode:
  - md = instr_valid && q_imem[31:27]==00000 && q_imem[6:2] in {00110 mul, 00111 div}.
  - rd = q_imem[26:22].
- States: IDLE, ISSUE, WAIT, WRITE. Reset to IDLE.
- Reset (async, reset_n low): IDLE; all outputs 0; latched op, rd, result, exception flag and counter cleared. Reset mid-op abandons the op with no writeback. A late data_resultRDY arriving in IDLE is ignored.
- IDLE:
  - stall = md, combinational, so the PC does not advance on the decode cycle.
  - If md: latch op and rd; next state ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - stall=1.
  - ctrl_MULT=1 if op is mul, else ctrl_DIV=1; never both.
  - Clear counter; next state WAIT.
- WAIT:
  - stall=1; counter increments each cycle.
  - If data_resultRDY: latch data_result and data_exception; next state WRITE.
  - Else if counter==TIMEOUT-1: set exception flag; next state WRITE.
  - RDY and timeout in the same cycle: RDY wins.
- WRITE (1 cycle):
  - stall=0, so the PC advances on this edge.
  - If exception: wb_en=1, wb_addr=30, wb_data = MUL_EXC_CODE or DIV_EXC_CODE, zero-extended to 32 bits.
  - Else if rd==0: wb_en=0 (r0 hardwired).
  - Else: wb_en=1, wb_addr=rd, wb_data=latched result.
  - Next state IDLE. The decoder ignores q_imem during WRITE.
- busy = (state != IDLE).
- wb_addr and wb_data are 0 whenever wb_en=0.
- Latency: decode cycle T0, ISSUE T1, first WAIT T2. RDY at Tk gives WRITE at Tk+1. Minimum total is 4 cycles (RDY at T2, WRITE at T3).
- Back-to-back md instructions: the next one is decoded in the cycle after WRITE, with no gap lost.
- instr_valid low in IDLE: no action, stall=0.

Decomposition:
- Package md_pkg:
  - opcode constants OP_ALU=5'b00000;
  - ALU-op constants ALUOP_MUL=5'b00110, ALUOP_DIV=5'b00111;
  - REG_STATUS=5'd30;
  - state enum {IDLE, ISSUE, WAIT, WRITE}.
- Sub-module md_decode (combinational):
  - input: q_imem, instr_valid;
  - outputs: is_mul, is_div, rd.
- The FSM, counter and writeback mux stay in the top module.

Test Plan:
- mul r3,r1,r2 (q_imem=0x00C22018); unit raises RDY with result 0x0000002A three cycles after ctrl_MULT -> ctrl_MULT high exactly at T1; stall high at T0–T4; WRITE at T5 with wb_en=1, wb_addr=3, wb_data=0x2A.
- div r4,r5,r6 (0x010A601C); RDY with data_exception=1 -> ctrl_DIV pulse only; WRITE with wb_addr=30, wb_data=5.
- mul with rd=0 (0x00022018), result 0x7 -> full sequence runs; wb_en stays 0 throughout.
- Unit never returns RDY, TIMEOUT=64 -> WRITE at T66 (64 WAIT cycles, T2–T65) with wb_addr=30, wb_data=4.
- reset_n low during WAIT, then a late RDY pulse -> all outputs 0 immediately; IDLE; late RDY causes no writeback.
- Non-md ALU add (aluop 00000) and an md word with instr_valid=0 -> stall=0, busy=0, no ctrl pulses.
